rdx2_stage_sequencer: RTL and testbench
=======================================

RDX2_STAGE_SEQUENCER -- requirements
Module: rdx2_stage_sequencer

Interface
REQ-001 Parameter b_fftp, default 12, log2 of FFT length N; SHALL be 4..12.
REQ-002 Parameter STAGE_GAP, default 8, idle cycles inserted between stages for butterfly pipeline flush; SHALL be 0..255.
REQ-003 Port Clock  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 Port Reset  input  1  asynchronous, active-high reset.
REQ-005 Port ClockEn  input  1  global enable; when low, all state and outputs SHALL hold.
REQ-006 Port Start  input  1  single-cycle request to begin a full N-point transform.
REQ-007 Port Busy  output  1  high from the cycle after Start is accepted until Done.
REQ-008 Port Done  output  1  one-cycle completion pulse.
REQ-009 Port Theta  output  b_fftp-1  twiddle index driven to the twiddle generator (3-cycle latency).
REQ-010 Port Stage  output  ceil(log2(b_fftp))  current stage number, aligned with Theta.
REQ-011 Port AddrA, AddrB  output  b_fftp each  butterfly operand addresses, delayed to align with twiddle Re/Im.
REQ-012 Port BflyValid  output  1  qualifies AddrA/AddrB, aligned with twiddle Re/Im.

Function
REQ-013 States SHALL be IDLE, RUN, GAP, DRAIN; reset state IDLE.
REQ-014 IDLE: Start high with ClockEn high SHALL move to RUN next cycle, Stage=0, k=0, Busy=1; Start in any other state SHALL be ignored.
REQ-015 RUN: one butterfly per enabled cycle, counter k = 0..N/2-1.
REQ-016 For stage s, span=2^s, j=k mod span, g=k>>s: address A = g*2*span + j, B = A + span, Theta = j<<(b_fftp-1-s), all registered in the RUN cycle.
REQ-017 At k=N/2-1 of a non-final stage: go to GAP when STAGE_GAP>0, else directly to RUN with Stage+1, k=0 (no bubble).
REQ-018 GAP SHALL last exactly STAGE_GAP enabled cycles, then RUN with Stage+1, k=0.
REQ-019 At k=N/2-1 of stage b_fftp-1: go to DRAIN for exactly 3 enabled cycles, then IDLE.
REQ-020 Raw valid is high only in RUN; AddrA, AddrB, BflyValid SHALL be that raw valid and addresses delayed by a 3-stage ClockEn-gated shift register.
REQ-021 Done SHALL pulse for one cycle on the DRAIN->IDLE transition; Busy SHALL fall in that same cycle.
REQ-022 Theta SHALL be 0 and Stage hold last value outside RUN; BflyValid low except on delayed RUN beats.
REQ-023 Total cycles Start-accept to Done = b_fftp*N/2 + (b_fftp-1)*STAGE_GAP + 3 + 1.
REQ-024 ClockEn low SHALL freeze FSM, counters and delay line; no beat lost or duplicated.

Reset
REQ-025 Reset high SHALL asynchronously force IDLE and zero Busy, Done, Theta, Stage, AddrA, AddrB, BflyValid, all counters and delay-line contents.
REQ-026 Reset mid-transform SHALL abandon it with no Done; next Start after release begins at stage 0.

Configuration
REQ-027 Macro RDX2SEQ_ABORT_EN: when defined, adds input Abort (1 bit); Abort high with ClockEn in RUN/GAP/DRAIN SHALL go to IDLE next cycle, clear delay-line valids, Busy low, no Done.
REQ-028 Without RDX2SEQ_ABORT_EN: no Abort port; transform always runs to completion.

Verification
REQ-029 b_fftp=4, STAGE_GAP=0, Start -> stage 0 pairs (0,1),(2,3)..(14,15), Theta all 0; BflyValid first high 3 cycles after first RUN cycle.
REQ-030 b_fftp=4 -> stage 1 Theta sequence 0,4,0,4..; stage 3 pairs (0,8)..(7,15), Theta 0..7.
REQ-031 b_fftp=4, STAGE_GAP=2 -> Done 4*8+3*2+3+1=42 cycles after Start accept; Busy falls with Done; exactly 32 BflyValid beats.
REQ-032 ClockEn toggled pseudo-randomly during run -> identical address/Theta sequence, 32 valid beats.
REQ-033 Start reasserted while Busy -> ignored; Reset at stage 2 -> all outputs 0 immediately, no Done.
REQ-034 RDX2SEQ_ABORT_EN defined, Abort in GAP -> IDLE next cycle, BflyValid low, no Done; next Start restarts at stage 0.

Source files
------------

// File: rtl/rdx2_stage_sequencer.sv
// Radix-2 FFT stage sequencer: walks every butterfly of every stage and emits twiddle index and operand addresses.
// Optional feature: define RDX2SEQ_ABORT_EN to add an Abort input that cancels a running transform.
module rdx2_stage_sequencer #(
    parameter int b_fftp    = 12,
    parameter int STAGE_GAP = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        ClockEn,
    input  logic                        Start,
`ifdef RDX2SEQ_ABORT_EN
    input  logic                        Abort,
`endif
    output logic                        Busy,
    output logic                        Done,
    output logic [b_fftp-2:0]           Theta,
    output logic [$clog2(b_fftp)-1:0]   Stage,
    output logic [b_fftp-1:0]           AddrA,
    output logic [b_fftp-1:0]           AddrB,
    output logic                        BflyValid
);

    localparam int SW = $clog2(b_fftp);
    localparam int KW = b_fftp - 1;

    localparam logic [KW-1:0]     K_LAST     = '1;
    localparam logic [KW-1:0]     ONE_K      = KW'(1);
    localparam logic [SW-1:0]     ONE_S      = SW'(1);
    localparam logic [SW-1:0]     STAGE_LAST = SW'(b_fftp - 1);
    localparam logic [SW:0]       SHIFT_TOP  = (SW+1)'(b_fftp - 1);
    localparam logic [b_fftp-1:0] ONE_A      = b_fftp'(1);
    localparam logic [7:0]        GAP_LAST   = 8'(STAGE_GAP - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN
    } state_t;

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [SW-1:0]       r_stage;
    logic [7:0]          r_gapCnt;
    logic [1:0]          r_drainCnt;
    logic [KW-1:0]       r_theta;
    logic [b_fftp-1:0]   r_rawA;
    logic [b_fftp-1:0]   r_rawB;
    logic                r_busy;
    logic                r_done;

    logic [2:0]          r_vldDly;
    logic [b_fftp-1:0]   r_aDly [0:2];
    logic [b_fftp-1:0]   r_bDly [0:2];

    logic [KW-1:0]       w_nextK;
    logic [SW-1:0]       w_nextStage;
    logic [b_fftp-1:0]   w_nextA;
    logic [b_fftp-1:0]   w_nextB;
    logic [KW-1:0]       w_nextTheta;
    logic                w_loadRun;
    logic                w_rawValid;
    logic                w_abort;

    function automatic logic [b_fftp-1:0] spanMask(input logic [SW-1:0] s);
        return (ONE_A << s) - ONE_A;
    endfunction

    // Address A is k with a zero bit inserted at position s; B sets that bit.
    function automatic logic [b_fftp-1:0] calcAddrA(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [b_fftp-1:0] kw;
        logic [b_fftp-1:0] m;
        kw = {1'b0, k};
        m  = spanMask(s);
        return ((kw & ~m) << 1) | (kw & m);
    endfunction

    function automatic logic [b_fftp-1:0] calcAddrB(input logic [SW-1:0] s, input logic [KW-1:0] k);
        return calcAddrA(s, k) | (ONE_A << s);
    endfunction

    function automatic logic [KW-1:0] calcTheta(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [b_fftp-1:0] m;
        logic [KW-1:0]     j;
        logic [SW:0]       sh;
        m  = spanMask(s);
        j  = k & m[KW-1:0];
        sh = SHIFT_TOP - {1'b0, s};
        return j << sh;
    endfunction

`ifdef RDX2SEQ_ABORT_EN
    assign w_abort = Abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_rawValid = (r_state == RUN);

    // Coordinates of the butterfly that the next RUN cycle would issue.
    always_comb begin
        w_nextK     = '0;
        w_nextStage = r_stage + ONE_S;
        if (r_state == IDLE) begin
            w_nextStage = '0;
        end else if ((r_state == RUN) && (r_k != K_LAST)) begin
            w_nextK     = r_k + ONE_K;
            w_nextStage = r_stage;
        end
    end

    assign w_nextA     = calcAddrA(w_nextStage, w_nextK);
    assign w_nextB     = calcAddrB(w_nextStage, w_nextK);
    assign w_nextTheta = calcTheta(w_nextStage, w_nextK);

    always_comb begin
        w_loadRun = 1'b0;
        case (r_state)
            IDLE:    w_loadRun = Start;
            RUN:     w_loadRun = !((r_k == K_LAST) && ((r_stage == STAGE_LAST) || (STAGE_GAP > 0)));
            GAP:     w_loadRun = (r_gapCnt == GAP_LAST);
            default: w_loadRun = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_stage    <= '0;
            r_gapCnt   <= '0;
            r_drainCnt <= '0;
            r_theta    <= '0;
            r_rawA     <= '0;
            r_rawB     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (ClockEn) begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_theta <= '0;
            end else if (w_loadRun) begin
                r_state <= RUN;
                r_busy  <= 1'b1;
                r_stage <= w_nextStage;
                r_k     <= w_nextK;
                r_theta <= w_nextTheta;
                r_rawA  <= w_nextA;
                r_rawB  <= w_nextB;
            end else begin
                case (r_state)
                    RUN: begin
                        r_theta <= '0;
                        if (r_stage == STAGE_LAST) begin
                            r_state    <= DRAIN;
                            r_drainCnt <= '0;
                        end else begin
                            r_state  <= GAP;
                            r_gapCnt <= '0;
                        end
                    end
                    GAP: begin
                        r_gapCnt <= r_gapCnt + 8'd1;
                    end
                    DRAIN: begin
                        if (r_drainCnt == DRAIN_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_drainCnt <= r_drainCnt + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Three-deep delay so addresses line up with the twiddle generator output.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_vldDly <= '0;
            for (int i = 0; i < 3; i++) begin
                r_aDly[i] <= '0;
                r_bDly[i] <= '0;
            end
        end else if (ClockEn) begin
            r_vldDly  <= w_abort ? 3'b000 : {r_vldDly[1:0], w_rawValid};
            r_aDly[0] <= r_rawA;
            r_bDly[0] <= r_rawB;
            for (int i = 1; i < 3; i++) begin
                r_aDly[i] <= r_aDly[i-1];
                r_bDly[i] <= r_bDly[i-1];
            end
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Theta     = r_theta;
    assign Stage     = r_stage;
    assign AddrA     = r_aDly[2];
    assign AddrB     = r_bDly[2];
    assign BflyValid = r_vldDly[2];

endmodule

// File: tb/tb_rdx2_stage_sequencer.sv
// Randomized bench for rdx2_stage_sequencer (b_fftp=4, STAGE_GAP=2) against a cycle-schedule reference model.
// Exercises the Abort input only when RDX2SEQ_ABORT_EN is defined.
module tb_rdx2_stage_sequencer;

    localparam int B     = 4;
    localparam int G     = 2;
    localparam int HALF  = 1 << (B - 1);
    localparam int TOTAL = B * HALF + (B - 1) * G + 3 + 1;
    localparam int SW    = $clog2(B);

    logic          Clock = 1'b0;
    logic          Reset;
    logic          ClockEn;
    logic          Start;
    logic          Busy;
    logic          Done;
    logic [B-2:0]  Theta;
    logic [SW-1:0] Stage;
    logic [B-1:0]  AddrA;
    logic [B-1:0]  AddrB;
    logic          BflyValid;
`ifdef RDX2SEQ_ABORT_EN
    logic          Abort = 1'b0;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    bit mAct      = 1'b0;
    int mC        = 0;
    int mStage    = 0;
    int beatCnt   = 0;
    bit prevValid = 1'b0;

    rdx2_stage_sequencer #(
        .b_fftp    (B),
        .STAGE_GAP (G)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ClockEn   (ClockEn),
        .Start     (Start),
`ifdef RDX2SEQ_ABORT_EN
        .Abort     (Abort),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Theta     (Theta),
        .Stage     (Stage),
        .AddrA     (AddrA),
        .AddrB     (AddrB),
        .BflyValid (BflyValid)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit en);
        @(negedge Clock);
        Start   = st;
        ClockEn = en;
    endtask

    // Cycle c counts enabled cycles since the accept edge; c=1 is the first butterfly.
    function automatic bit runCoord(input int c, output int s, output int k);
        int idx;
        s = 0;
        k = 0;
        if (c < 1) return 1'b0;
        idx = c - 1;
        s = idx / (HALF + G);
        k = idx % (HALF + G);
        return (s < B) && (k < HALF);
    endfunction

    function automatic int stageAt(input int c);
        int s;
        s = (c - 1) / (HALF + G);
        return (s > B - 1) ? B - 1 : s;
    endfunction

    function automatic int thetaOf(input int s, input int k);
        return (k % (1 << s)) * (1 << (B - 1 - s));
    endfunction

    function automatic int addrAOf(input int s, input int k);
        int span;
        span = 1 << s;
        return (k / span) * 2 * span + (k % span);
    endfunction

    always begin
        bit en, st, rs, ab, isRun;
        int s, k, eStage;
        @(posedge Clock);
        en = ClockEn;
        st = Start;
        rs = Reset;
        ab = 1'b0;
`ifdef RDX2SEQ_ABORT_EN
        ab = Abort;
`endif
        if (rs) begin
            mAct   = 1'b0;
            mC     = 0;
            mStage = 0;
        end else if (en) begin
            if (prevValid) beatCnt++;
            if (mAct && mC < TOTAL && ab) begin
                mAct = 1'b0;
                mC   = 0;
            end else if (mAct && mC < TOTAL) begin
                mC++;
                if (mC == TOTAL) checkOutput("beatCount", beatCnt, B * HALF);
            end else if (st) begin
                mAct    = 1'b1;
                mC      = 1;
                beatCnt = 0;
            end else begin
                mAct = 1'b0;
                mC   = 0;
            end
        end
        #1;
        if (rs) begin
            checkOutput("rstBusy", int'(Busy), 0);
            checkOutput("rstDone", int'(Done), 0);
            checkOutput("rstTheta", int'(Theta), 0);
            checkOutput("rstStage", int'(Stage), 0);
            checkOutput("rstValid", int'(BflyValid), 0);
            checkOutput("rstAddrA", int'(AddrA), 0);
            checkOutput("rstAddrB", int'(AddrB), 0);
        end else if (mAct) begin
            eStage = stageAt(mC);
            mStage = eStage;
            isRun  = runCoord(mC, s, k);
            checkOutput("busy", int'(Busy), int'(mC < TOTAL));
            checkOutput("done", int'(Done), int'(mC == TOTAL));
            checkOutput("stage", int'(Stage), eStage);
            checkOutput("theta", int'(Theta), isRun ? thetaOf(s, k) : 0);
            isRun = runCoord(mC - 3, s, k);
            checkOutput("bflyValid", int'(BflyValid), int'(isRun));
            if (isRun) begin
                checkOutput("addrA", int'(AddrA), addrAOf(s, k));
                checkOutput("addrB", int'(AddrB), addrAOf(s, k) + (1 << s));
            end
        end else begin
            checkOutput("idleBusy", int'(Busy), 0);
            checkOutput("idleDone", int'(Done), 0);
            checkOutput("idleTheta", int'(Theta), 0);
            checkOutput("idleStage", int'(Stage), mStage);
            checkOutput("idleValid", int'(BflyValid), 0);
        end
        prevValid = BflyValid;
    end

    task automatic waitModelIdle();
        int n;
        n = 0;
        while (mAct && mC != TOTAL && n < 3000) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        checkOutput("runTimeout", int'(n < 3000), 1);
        repeat (3) applyStimulus(1'b0, 1'b1);
    endtask

    initial begin
        Reset   = 1'b1;
        ClockEn = 1'b0;
        Start   = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b1);
        @(negedge Clock);
        Reset = 1'b0;

        // Full transform with a stray Start mid-run.
        applyStimulus(1'b1, 1'b1);
        repeat (15) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        waitModelIdle();

        // Random ClockEn gaps and random Start requests.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        waitModelIdle();

        // Reset while stage 2 is in progress.
        applyStimulus(1'b1, 1'b1);
        repeat (22) applyStimulus(1'b0, 1'b1);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checkOutput("asyncBusy", int'(Busy), 0);
        checkOutput("asyncDone", int'(Done), 0);
        checkOutput("asyncTheta", int'(Theta), 0);
        checkOutput("asyncStage", int'(Stage), 0);
        checkOutput("asyncValid", int'(BflyValid), 0);
        checkOutput("asyncAddrA", int'(AddrA), 0);
        checkOutput("asyncAddrB", int'(AddrB), 0);
        repeat (2) applyStimulus(1'b1, 1'b1);
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        applyStimulus(1'b1, 1'b1);
        waitModelIdle();

`ifdef RDX2SEQ_ABORT_EN
        applyStimulus(1'b1, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b1);
        @(negedge Clock);
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        waitModelIdle();
`endif

        repeat (5) applyStimulus(1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
